// File: rtl/barrel_shifter_top.sv
// barrel_shifter_top: registered WIDTH-bit right barrel rotator.
//
// DOUT takes DIN rotated right by SEL one cycle after DIN and SEL are
// sampled: bit i of the result is DIN[(i+SEL) mod WIDTH]. The network has
// SEL_WIDTH cascaded stages. Stage s moves the word right by 2^s when
// SEL[s] is set, and passes it through otherwise. Only the final result is
// registered.
//
// Optional feature (macro BARREL_SHIFTER_LOGICAL_EN):
//   defined   - logical right shift; vacated MSBs fill with 0.
//   undefined - right rotate (default).
//
// Ports:
//   clk   in   1          rising-edge clock
//   rst_n in   1          synchronous active-low reset, clears DOUT
//   DIN   in   WIDTH      data word
//   SEL   in   SEL_WIDTH  shift/rotate amount, 0..WIDTH-1
//   DOUT  out  WIDTH      registered result

// One mux stage with a fixed shift distance AMT (a power of two).
module barrel_shifter_stage #(
    parameter int WIDTH = 4,
    parameter int AMT   = 1
) (
    input  logic [WIDTH-1:0] din,
    input  logic             en,
    output logic [WIDTH-1:0] dout
);
    logic [WIDTH-1:0] moved;

    always_comb begin
`ifdef BARREL_SHIFTER_LOGICAL_EN
        moved = din >> AMT;
`else
        // Bits leaving the LSB end wrap back in at the MSB end.
        moved = (din >> AMT) | (din << (WIDTH - AMT));
`endif
        dout = en ? moved : din;
    end
endmodule

module barrel_shifter_top #(
    parameter  int WIDTH     = 4,
    localparam int SEL_WIDTH = $clog2(WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     DIN,
    input  logic [SEL_WIDTH-1:0] SEL,
    output logic [WIDTH-1:0]     DOUT
);
    // stage_data[0] is the raw input, and stage_data[SEL_WIDTH] is the fully shifted word.
    logic [SEL_WIDTH:0][WIDTH-1:0] stage_data;
    logic [WIDTH-1:0]              dout_d;
    logic [WIDTH-1:0]              dout_q;

    assign stage_data[0] = DIN;

    for (genvar s = 0; s < SEL_WIDTH; s++) begin : g_stage
        barrel_shifter_stage #(
            .WIDTH (WIDTH),
            .AMT   (1 << s)
        ) u_stage (
            .din  (stage_data[s]),
            .en   (SEL[s]),
            .dout (stage_data[s+1])
        );
    end

    always_comb begin
        dout_d = stage_data[SEL_WIDTH];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) dout_q <= '0;
        else        dout_q <= dout_d;
    end

    assign DOUT = dout_q;
endmodule

// File: tb/tb_barrel_shifter_top.sv
// Self-checking bench for barrel_shifter_top (WIDTH=4). Runs the directed
// cases, then random traffic with occasional single-cycle resets, and
// compares DOUT against a bit-index reference model.
module tb_barrel_shifter_top;
    localparam int W  = 4;
    localparam int SW = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [W-1:0]  din;
    logic [SW-1:0] sel;
    logic [W-1:0]  dout;

    int n_chk  = 0;
    int n_fail = 0;
    logic [W-1:0] prev_exp;
    bit           have_prev = 1'b0;

    barrel_shifter_top #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .DIN   (din),
        .SEL   (sel),
        .DOUT  (dout)
    );

    always #5 clk = ~clk;

    // Reference model. Each result bit is read from the source position.
    function automatic logic [W-1:0] ref_model(input logic [W-1:0] d, input int s);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < W; i++) begin
`ifdef BARREL_SHIFTER_LOGICAL_EN
            r[i] = (i + s < W) ? d[i+s] : 1'b0;
`else
            r[i] = d[(i + s) % W];
`endif
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%b exp=%b @%0t", tag, got, exp, $time);
        end
    endtask

    // Drive one cycle. Inputs change 1ns after an edge. DOUT must keep the
    // previous result until the next edge. After that edge it must show the
    // model value, or 0 while reset is asserted.
    task automatic step(input logic [W-1:0] d, input logic [SW-1:0] s, input logic r,
                        input string tag);
        logic [W-1:0] exp;
        din   = d;
        sel   = s;
        rst_n = r;
        exp   = r ? ref_model(d, int'(s)) : '0;
        if (have_prev) begin
            #2;
            chk({tag, "_hold"}, dout, prev_exp);
        end
        @(posedge clk);
        #1;
        chk(tag, dout, exp);
        prev_exp  = exp;
        have_prev = 1'b1;
    endtask

    logic [W-1:0] sweep_exp [4];
    logic [W-1:0] wrap_din  [3];
    logic [SW-1:0] wrap_sel [3];
    logic [W-1:0] wrap_exp  [3];

    initial begin
`ifdef BARREL_SHIFTER_LOGICAL_EN
        sweep_exp = '{4'b1011, 4'b0101, 4'b0010, 4'b0001};
        wrap_exp  = '{4'b0010, 4'b0001, 4'b0010};
`else
        sweep_exp = '{4'b1011, 4'b1101, 4'b1110, 4'b0111};
        wrap_exp  = '{4'b1010, 4'b0001, 4'b0110};
`endif
        wrap_din = '{4'b0101, 4'b1000, 4'b1001};
        wrap_sel = '{2'd1, 2'd3, 2'd2};

        din   = '0;
        sel   = '0;
        rst_n = 1'b0;
        @(negedge clk);

        // Hold reset for two edges, then release.
        step(4'b1111, 2'b01, 1'b0, "rst0");
        chk("rst0_val", dout, 4'b0000);
        step(4'b1111, 2'b01, 1'b0, "rst1");
        step(4'b1111, 2'b01, 1'b1, "rst_rel");
`ifndef BARREL_SHIFTER_LOGICAL_EN
        chk("rst_rel_val", dout, 4'b1111);
`endif

        // Sweep SEL across all values with a fixed DIN.
        for (int s = 0; s < 4; s++) begin
            step(4'b1011, SW'(s), 1'b1, "sweep");
            chk("sweep_const", dout, sweep_exp[s]);
        end

        // Wrap cases.
        for (int k = 0; k < 3; k++) begin
            step(wrap_din[k], wrap_sel[k], 1'b1, "wrap");
            chk("wrap_const", dout, wrap_exp[k]);
        end

        // All-ones and all-zeros inputs.
        for (int s = 0; s < 4; s++) begin
            step(4'b1111, SW'(s), 1'b1, "ones");
`ifndef BARREL_SHIFTER_LOGICAL_EN
            chk("ones_inv", dout, 4'b1111);
`endif
            step(4'b0000, SW'(s), 1'b1, "zeros");
            chk("zeros_inv", dout, 4'b0000);
        end

        // Back-to-back inputs with one reset edge in the middle.
        for (int k = 0; k < 6; k++)
            step(W'($urandom), SW'($urandom), (k != 3), "midrst");

        // Random traffic with occasional single-cycle resets.
        for (int k = 0; k < 300; k++)
            step(W'($urandom), SW'($urandom), ($urandom_range(0, 15) != 0), "rand");

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/barrel_shifter_top.md
Name: barrel_shifter_top

Overview:
Registered N-bit right barrel rotator. Each clock it rotates data word DIN right by SEL bit positions and registers the result on DOUT. The datapath is a log2(WIDTH)-stage mux network followed by one output register. It is used as a leaf datapath block; default configuration is 4-bit data with a 2-bit shift amount.

Parameters:
WIDTH, 4, data width in bits; must be a power of two and >= 2.
SEL_WIDTH, $clog2(WIDTH) (localparam, derived), shift-amount width; default 2.

Ports:
clk  input  1  rising-edge clock, sole clock domain.
rst_n  input  1  synchronous active-low reset, sampled on rising clk edge.
DIN  input  WIDTH  data word to rotate.
SEL  input  SEL_WIDTH  rotate amount, unsigned, range 0..WIDTH-1.
DOUT  output  WIDTH  registered rotated result.

Behaviour:
- Interface: one clock (clk); reset rst_n is synchronous and active-low; no asynchronous reset path.
- Reset: on a rising clk edge with rst_n=0, DOUT <= 0. This overrides the datapath regardless of DIN and SEL.
- Normal operation: on every rising clk edge with rst_n=1, DOUT <= DIN rotated right by SEL. Bit i of the result = DIN[(i+SEL) mod WIDTH].
- Latency: exactly 1 cycle. DIN/SEL sampled at edge k appear on DOUT after edge k. There is no valid/ready handshake; a new operation is accepted every cycle.
- Structure: SEL_WIDTH cascaded stages. Stage s rotates right by 2^s when SEL[s]=1, else passes through. Only the final result is registered; there are no internal pipeline registers.
- SEL=0: DOUT = DIN (pass-through, registered).
- SEL covers exactly 0..WIDTH-1, so no out-of-range case exists. Rotate wraps modulo WIDTH, and bits shifted out of the LSB re-enter at the MSB.
- All-ones and all-zeros inputs are invariant under rotation.
- Reset deasserting: first non-reset edge loads the rotated DIN normally; no extra warm-up cycle.
- Reset asserted mid-stream: DOUT goes to 0 on that edge; the in-flight result is discarded.
- No X propagation from unused logic; DOUT is always driven from the register.

Optional Feature:
Macro BARREL_SHIFTER_LOGICAL_EN.
- Defined: block performs a logical right shift instead of a rotate. Vacated MSBs fill with 0: bit i = DIN[i+SEL] if i+SEL < WIDTH, else 0. Latency, reset and port list are unchanged.
- Undefined (default): right rotate as specified above.

Test Plan:
- Reset: rst_n=0 for 2 edges with DIN=4'b1111, SEL=2'b01 -> DOUT=4'b0000. Release -> next edge DOUT=4'b1111.
- Full sweep, DIN=4'b1011, SEL=0,1,2,3 on consecutive cycles -> DOUT one cycle later = 1011, 1101, 1110, 0111.
- Wrap cases: DIN=4'b0101, SEL=1 -> 1010. DIN=4'b1000, SEL=3 -> 0001. DIN=4'b1001, SEL=2 -> 0110.
- Invariance: DIN=4'b1111 and DIN=4'b0000, all SEL values -> DOUT equals DIN every time.
- Mid-stream reset and back-to-back: change DIN/SEL every cycle, assert rst_n=0 for one edge -> DOUT=0 on that edge only. Results before and after match the reference rotate with exactly 1-cycle latency.
- With BARREL_SHIFTER_LOGICAL_EN: DIN=4'b1011, SEL=0..3 -> 1011, 0101, 0010, 0001.
